// File: rtl/rv32i_types.sv
// Shared rv32i pipeline types used by the memory-access stage.
package rv32i_types;

   // Memory stage FSM: waiting for nothing, or for one outstanding response.
   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

   // Load funct3 encodings. Stores reuse the low encodings: sb=MEM_B, sh=MEM_H, sw=MEM_W.
   typedef enum logic [2:0] {
      MEM_B  = 3'b000,
      MEM_H  = 3'b001,
      MEM_W  = 3'b010,
      MEM_BU = 3'b100,
      MEM_HU = 3'b101
   } mem_f3_t;

   typedef struct packed {
      logic       regf_we;
      logic [1:0] wb_sel;
   } wb_ctrl_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] alu_out;
      logic [31:0] rs2_v;
      logic [2:0]  funct3;
      logic        mem_read;
      logic        mem_write;
      logic        br_en;
      logic [31:0] u_imm;
      logic [4:0]  rd_s;
      wb_ctrl_t    wb_ctrl;
   } ex_mem_stage_reg_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] alu_out_s;
      logic        br_en;
      logic [31:0] u_imm;
      logic [4:0]  rd_s;
      wb_ctrl_t    wb_ctrl;
      logic [31:0] dmem_addr_s;
      logic [31:0] dmem_rdata_s;
      logic        misalign_s;
   } mem_wb_stage_reg_t;

endpackage

// File: rtl/mem_stage_mask_gen.sv
// Byte-lane mask, store-data shift and alignment check for one memory op.
module mem_mask_gen
   import rv32i_types::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] rs2_v,
   output logic [3:0]  rmask,
   output logic [3:0]  wmask,
   output logic [31:0] wdata,
   output logic        misalign
);

   logic [3:0] base;
   logic       bad_align;

   // Access size from funct3; unknown encodings are treated as word accesses.
   always_comb begin
      base      = 4'b1111;
      bad_align = (off != 2'b00);
      case (funct3)
         MEM_B, MEM_BU: begin
            base      = 4'b0001;
            bad_align = 1'b0;
         end
         MEM_H, MEM_HU: begin
            base      = 4'b0011;
            bad_align = off[0];
         end
         default: ;
      endcase
   end

   assign rmask    = mem_read  ? (base << off) : 4'b0000;
   assign wmask    = mem_write ? (base << off) : 4'b0000;
   assign wdata    = rs2_v << {off, 3'b000};
   assign misalign = (mem_read | mem_write) & bad_align;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues one masked dmem request per load/store,
// stalls until the response, and registers the result towards writeback.
//
// Handshake: a request is presented (nonzero mask) for exactly the single IDLE
// cycle in which it is issued; the memory answers with a one-cycle dmem_resp
// pulse no earlier than the following cycle, and dmem_resp is only honoured in
// WAIT. While mem_stall=1 upstream holds ex_mem_reg stable.
module mem_stage
   import rv32i_types::*;
(
   input  logic              clk,
   input  logic              rst,
   input  ex_mem_stage_reg_t ex_mem_reg,
   output logic [31:0]       dmem_addr,
   output logic [3:0]        dmem_rmask,
   output logic [3:0]        dmem_wmask,
   output logic [31:0]       dmem_wdata,
   input  logic [31:0]       dmem_rdata,
   input  logic              dmem_resp,
   output logic              mem_stall,
   output mem_wb_stage_reg_t mem_wb_reg
);

   mem_state_t        state, state_next;
   logic              mem_op, issue, commit;
   logic [3:0]        rmask, wmask;
   logic [31:0]       wdata;
   logic              misalign;
   mem_wb_stage_reg_t wb_next;

   mem_mask_gen u_mask_gen (
      .funct3    (ex_mem_reg.funct3),
      .off       (ex_mem_reg.alu_out[1:0]),
      .mem_read  (ex_mem_reg.mem_read),
      .mem_write (ex_mem_reg.mem_write),
      .rs2_v     (ex_mem_reg.rs2_v),
      .rmask     (rmask),
      .wmask     (wmask),
      .wdata     (wdata),
      .misalign  (misalign)
   );

   assign mem_op = ex_mem_reg.valid & (ex_mem_reg.mem_read | ex_mem_reg.mem_write);

   // Next state, stall, and whether the writeback register takes a commit this cycle.
   always_comb begin
      state_next = state;
      mem_stall  = 1'b0;
      issue      = 1'b0;
      commit     = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (mem_op && !misalign) begin
                  issue      = 1'b1;
                  mem_stall  = 1'b1;
                  state_next = WAIT;
               end else begin
                  commit = 1'b1;
               end
            end
            WAIT: begin
               if (dmem_resp) begin
                  commit     = 1'b1;
                  state_next = IDLE;
               end else begin
                  mem_stall = 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // The bus is quiet (all zero) outside the issue cycle, including address and data.
   assign dmem_addr  = issue ? {ex_mem_reg.alu_out[31:2], 2'b00} : 32'h0;
   assign dmem_rmask = issue ? rmask : 4'b0000;
   assign dmem_wmask = issue ? wmask : 4'b0000;
   assign dmem_wdata = issue ? wdata : 32'h0;

   // Writeback payload; a misaligned memory op is passed on with its register write killed.
   always_comb begin
      wb_next                 = '0;
      wb_next.valid           = ex_mem_reg.valid;
      wb_next.alu_out_s       = ex_mem_reg.alu_out;
      wb_next.br_en           = ex_mem_reg.br_en;
      wb_next.u_imm           = ex_mem_reg.u_imm;
      wb_next.rd_s            = ex_mem_reg.rd_s;
      wb_next.wb_ctrl         = ex_mem_reg.wb_ctrl;
      wb_next.wb_ctrl.regf_we = ex_mem_reg.wb_ctrl.regf_we & ~(mem_op & misalign);
      wb_next.dmem_addr_s     = ex_mem_reg.alu_out;
      wb_next.dmem_rdata_s    = (state == WAIT && ex_mem_reg.mem_read) ? dmem_rdata : 32'h0;
      wb_next.misalign_s      = mem_op & misalign;
   end

   // State register and writeback register; non-commit cycles insert a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         mem_wb_reg <= '0;
      end else begin
         state <= state_next;
         if (commit) mem_wb_reg <= wb_next;
         else        mem_wb_reg <= '0;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores, misalignment,
// back-to-back ops and reset while waiting.
module tb_mem_stage;
   import rv32i_types::*;

   logic              clk = 1'b0;
   logic              rst;
   ex_mem_stage_reg_t ex_mem_reg;
   logic [31:0]       dmem_addr;
   logic [3:0]        dmem_rmask;
   logic [3:0]        dmem_wmask;
   logic [31:0]       dmem_wdata;
   logic [31:0]       dmem_rdata;
   logic              dmem_resp;
   logic              mem_stall;
   mem_wb_stage_reg_t mem_wb_reg;

   int vectors     = 0;
   int miscompares = 0;

   mem_stage dut (
      .clk        (clk),
      .rst        (rst),
      .ex_mem_reg (ex_mem_reg),
      .dmem_addr  (dmem_addr),
      .dmem_rmask (dmem_rmask),
      .dmem_wmask (dmem_wmask),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .dmem_resp  (dmem_resp),
      .mem_stall  (mem_stall),
      .mem_wb_reg (mem_wb_reg)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; registered outputs are then stable.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after an input change.
   task automatic settle();
      #1;
   endtask

   function automatic ex_mem_stage_reg_t mk(input logic v, input logic [31:0] alu,
                                            input logic [31:0] rs2, input logic [2:0] f3,
                                            input logic rd, input logic wr);
      ex_mem_stage_reg_t e;
      e                 = '0;
      e.valid           = v;
      e.alu_out         = alu;
      e.rs2_v           = rs2;
      e.funct3          = f3;
      e.mem_read        = rd;
      e.mem_write       = wr;
      e.rd_s            = 5'd7;
      e.u_imm           = 32'h0000_5000;
      e.wb_ctrl.regf_we = ~wr;
      e.wb_ctrl.wb_sel  = 2'b01;
      return e;
   endfunction

   initial begin
      rst        = 1'b1;
      ex_mem_reg = '0;
      dmem_rdata = 32'h0;
      dmem_resp  = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_state", 32'(dut.state), 32'(IDLE));
      check("rst_wb_valid", 32'(mem_wb_reg.valid), 32'h0);
      check("rst_wb_alu", mem_wb_reg.alu_out_s, 32'h0);
      check("rst_stall", 32'(mem_stall), 32'h0);
      check("rst_rmask", 32'(dmem_rmask), 32'h0);
      check("rst_wmask", 32'(dmem_wmask), 32'h0);
      check("rst_addr", dmem_addr, 32'h0);
      check("rst_wdata", dmem_wdata, 32'h0);
      rst = 1'b0;
      tick();

      // Pass-through ALU op
      ex_mem_reg = mk(1'b1, 32'h0000_1234, 32'h0, 3'b000, 1'b0, 1'b0);
      settle();
      check("alu_stall", 32'(mem_stall), 32'h0);
      check("alu_rmask", 32'(dmem_rmask), 32'h0);
      tick();
      ex_mem_reg = '0;
      check("alu_wb_valid", 32'(mem_wb_reg.valid), 32'h1);
      check("alu_wb_out", mem_wb_reg.alu_out_s, 32'h0000_1234);
      check("alu_wb_we", 32'(mem_wb_reg.wb_ctrl.regf_we), 32'h1);
      check("alu_wb_rd", 32'(mem_wb_reg.rd_s), 32'd7);

      // lb at 0x1003, response three cycles after issue
      ex_mem_reg = mk(1'b1, 32'h0000_1003, 32'h0, MEM_B, 1'b1, 1'b0);
      settle();
      check("lb_addr", dmem_addr, 32'h0000_1000);
      check("lb_rmask", 32'(dmem_rmask), 32'h8);
      check("lb_wmask", 32'(dmem_wmask), 32'h0);
      check("lb_stall0", 32'(mem_stall), 32'h1);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("lb_wait_state", 32'(dut.state), 32'(WAIT));
         check("lb_wait_stall", 32'(mem_stall), 32'h1);
         check("lb_wait_rmask", 32'(dmem_rmask), 32'h0);
         check("lb_bubble", 32'(mem_wb_reg.valid), 32'h0);
      end
      tick();
      dmem_resp  = 1'b1;
      dmem_rdata = 32'hAB00_0000;
      settle();
      check("lb_resp_stall", 32'(mem_stall), 32'h0);
      check("lb_resp_rmask", 32'(dmem_rmask), 32'h0);
      tick();
      dmem_resp  = 1'b0;
      dmem_rdata = 32'h0;
      ex_mem_reg = '0;
      check("lb_wb_valid", 32'(mem_wb_reg.valid), 32'h1);
      check("lb_wb_rdata", mem_wb_reg.dmem_rdata_s, 32'hAB00_0000);
      check("lb_wb_addr", mem_wb_reg.dmem_addr_s, 32'h0000_1003);
      check("lb_wb_we", 32'(mem_wb_reg.wb_ctrl.regf_we), 32'h1);
      check("lb_idle", 32'(dut.state), 32'(IDLE));

      // sh at 0x2002
      ex_mem_reg = mk(1'b1, 32'h0000_2002, 32'h0000_BEEF, MEM_H, 1'b0, 1'b1);
      settle();
      check("sh_wmask", 32'(dmem_wmask), 32'hC);
      check("sh_rmask", 32'(dmem_rmask), 32'h0);
      check("sh_wdata", dmem_wdata, 32'hBEEF_0000);
      check("sh_addr", dmem_addr, 32'h0000_2000);
      tick();
      check("sh_wait_wmask", 32'(dmem_wmask), 32'h0);
      check("sh_bubble", 32'(mem_wb_reg.valid), 32'h0);
      dmem_resp  = 1'b1;
      dmem_rdata = 32'h5555_5555;
      settle();
      check("sh_resp_stall", 32'(mem_stall), 32'h0);
      tick();
      dmem_resp  = 1'b0;
      ex_mem_reg = '0;
      check("sh_wb_valid", 32'(mem_wb_reg.valid), 32'h1);
      check("sh_wb_rdata", mem_wb_reg.dmem_rdata_s, 32'h0);
      check("sh_wb_addr", mem_wb_reg.dmem_addr_s, 32'h0000_2002);
      check("sh_wb_mis", 32'(mem_wb_reg.misalign_s), 32'h0);

      // Misaligned lw at 0x3001
      ex_mem_reg = mk(1'b1, 32'h0000_3001, 32'h0, MEM_W, 1'b1, 1'b0);
      settle();
      check("lw_mis_rmask", 32'(dmem_rmask), 32'h0);
      check("lw_mis_stall", 32'(mem_stall), 32'h0);
      tick();
      ex_mem_reg = '0;
      check("lw_mis_valid", 32'(mem_wb_reg.valid), 32'h1);
      check("lw_mis_flag", 32'(mem_wb_reg.misalign_s), 32'h1);
      check("lw_mis_we", 32'(mem_wb_reg.wb_ctrl.regf_we), 32'h0);
      check("lw_mis_state", 32'(dut.state), 32'(IDLE));

      // Misaligned lh at 0x3003 (odd halfword)
      ex_mem_reg = mk(1'b1, 32'h0000_3003, 32'h0, MEM_HU, 1'b1, 1'b0);
      settle();
      check("lh_mis_rmask", 32'(dmem_rmask), 32'h0);
      check("lh_mis_stall", 32'(mem_stall), 32'h0);
      tick();
      ex_mem_reg = '0;
      check("lh_mis_flag", 32'(mem_wb_reg.misalign_s), 32'h1);

      // sb at 0x4001: bytes are never misaligned
      ex_mem_reg = mk(1'b1, 32'h0000_4001, 32'h1234_5678, MEM_B, 1'b0, 1'b1);
      settle();
      check("sb_wmask", 32'(dmem_wmask), 32'h2);
      check("sb_wdata", dmem_wdata, 32'h3456_7800);
      check("sb_stall", 32'(mem_stall), 32'h1);
      tick();
      dmem_resp = 1'b1;
      tick();
      dmem_resp  = 1'b0;
      ex_mem_reg = '0;
      check("sb_wb_valid", 32'(mem_wb_reg.valid), 32'h1);
      check("sb_wb_mis", 32'(mem_wb_reg.misalign_s), 32'h0);

      // lw then sw back-to-back, latency 1
      ex_mem_reg = mk(1'b1, 32'h0000_5000, 32'h0, MEM_W, 1'b1, 1'b0);
      settle();
      check("b2b_lw_rmask", 32'(dmem_rmask), 32'hF);
      check("b2b_lw_addr", dmem_addr, 32'h0000_5000);
      tick();
      dmem_resp  = 1'b1;
      dmem_rdata = 32'hCAFE_F00D;
      settle();
      check("b2b_resp_stall", 32'(mem_stall), 32'h0);
      check("b2b_resp_rmask", 32'(dmem_rmask), 32'h0);
      check("b2b_resp_wmask", 32'(dmem_wmask), 32'h0);
      tick();
      dmem_resp  = 1'b0;
      dmem_rdata = 32'h0;
      ex_mem_reg = mk(1'b1, 32'h0000_5004, 32'h1122_3344, MEM_W, 1'b0, 1'b1);
      check("b2b_lw_valid", 32'(mem_wb_reg.valid), 32'h1);
      check("b2b_lw_rdata", mem_wb_reg.dmem_rdata_s, 32'hCAFE_F00D);
      settle();
      check("b2b_sw_wmask", 32'(dmem_wmask), 32'hF);
      check("b2b_sw_wdata", dmem_wdata, 32'h1122_3344);
      check("b2b_sw_addr", dmem_addr, 32'h0000_5004);
      check("b2b_sw_stall", 32'(mem_stall), 32'h1);
      tick();
      check("b2b_sw_bubble", 32'(mem_wb_reg.valid), 32'h0);
      check("b2b_sw_wait_wmask", 32'(dmem_wmask), 32'h0);
      dmem_resp = 1'b1;
      tick();
      dmem_resp  = 1'b0;
      ex_mem_reg = '0;
      check("b2b_sw_valid", 32'(mem_wb_reg.valid), 32'h1);
      check("b2b_sw_addr_s", mem_wb_reg.dmem_addr_s, 32'h0000_5004);
      check("b2b_sw_rdata", mem_wb_reg.dmem_rdata_s, 32'h0);

      // Reset while in WAIT, then a stray response
      ex_mem_reg = mk(1'b1, 32'h0000_6000, 32'h0, MEM_W, 1'b1, 1'b0);
      tick();
      check("rw_state_wait", 32'(dut.state), 32'(WAIT));
      rst = 1'b1;
      settle();
      check("rw_rst_stall", 32'(mem_stall), 32'h0);
      tick();
      rst        = 1'b0;
      ex_mem_reg = '0;
      check("rw_state", 32'(dut.state), 32'(IDLE));
      check("rw_wb_valid", 32'(mem_wb_reg.valid), 32'h0);
      dmem_resp  = 1'b1;
      dmem_rdata = 32'hDEAD_BEEF;
      settle();
      check("rw_stray_stall", 32'(mem_stall), 32'h0);
      check("rw_stray_rmask", 32'(dmem_rmask), 32'h0);
      tick();
      dmem_resp = 1'b0;
      check("rw_stray_state", 32'(dut.state), 32'(IDLE));
      check("rw_stray_valid", 32'(mem_wb_reg.valid), 32'h0);
      check("rw_stray_rdata", mem_wb_reg.dmem_rdata_s, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the rv32i five-stage pipeline: it sits between the EX/MEM pipeline register and the writeback stage. It turns load/store instructions into byte-masked, word-aligned data-memory requests, and stalls the pipeline until the response arrives. It also captures and forwards `mem_wb_reg`, including the raw load data, to writeback. Non-memory instructions pass through in one cycle.

## Interface
- No parameters; widths are fixed by the RV32I ISA.
- `clk`  in  1  pipeline clock
- `rst`  in  1  synchronous, active-high reset
- `ex_mem_reg`  in  `ex_mem_stage_reg_t`  upstream register. Fields: `valid`, `alu_out`, `rs2_v`, `funct3`, `mem_read`, `mem_write`, `br_en`, `u_imm`, `rd_s`, `wb_ctrl`.
- `dmem_addr`  out  32  word-aligned request address, `{alu_out[31:2],2'b00}`
- `dmem_rmask`  out  4  byte read mask; nonzero only in the issue cycle
- `dmem_wmask`  out  4  byte write mask; nonzero only in the issue cycle
- `dmem_wdata`  out  32  lane-shifted store data
- `dmem_rdata`  in  32  response data; valid with `dmem_resp`
- `dmem_resp`  in  1  one-cycle response pulse
- `mem_stall`  out  1  freeze IF/ID/EX and hold `ex_mem_reg`
- `mem_wb_reg`  out  `mem_wb_stage_reg_t`  registered output to writeback

## Operation
- **FSM states:** `IDLE`, `WAIT`. Reset puts the FSM in `IDLE`.
- **Memory op:** `ex_mem_reg.valid & (mem_read | mem_write)`.
- **Read masks** (`funct3`, `off = alu_out[1:0]`):
  - lb/lbu: `4'b0001<<off`
  - lh/lhu: `4'b0011<<off`
  - lw: `4'b1111`
- **Write masks** (same rule): sb, sh, sw.
- **Store data:** `dmem_wdata = rs2_v << (8*off)`.
- **Misaligned ops** (halfword with `off[0]=1`, word with `off!=0`):
  - no request is issued;
  - `mem_wb_reg.misalign_s=1` and `wb_ctrl.regf_we=0`;
  - 1-cycle pass-through.
- **IDLE + aligned memory op:**
  - drive masks/addr/wdata for exactly this cycle;
  - assert `mem_stall`;
  - go to `WAIT`;
  - `mem_wb_reg.valid` is loaded as 0 (bubble).
- **WAIT, no `dmem_resp`:** masks = 0, `mem_stall=1`, bubble into `mem_wb_reg`.
- **WAIT + `dmem_resp`:**
  - `mem_stall=0` in the same cycle (combinational);
  - at the edge, load `mem_wb_reg` from `ex_mem_reg` plus `dmem_rdata_s = dmem_rdata` and `dmem_addr_s = alu_out`;
  - go to `IDLE`.
- **Stores:** complete the same way. `dmem_rdata_s` is a don't-care and is written as 0.
- **Non-memory or invalid input:** copy to `mem_wb_reg` at the next edge; `mem_stall=0`.
- **Fields copied to `mem_wb_reg`:** `valid`, `alu_out`, `br_en`, `u_imm`, `rd_s`, `wb_ctrl`, `dmem_addr_s`, `dmem_rdata_s`, `misalign_s`.

## Timing
- **Reset values:**
  - `mem_wb_reg` all zeros (`valid=0`);
  - `dmem_rmask`, `dmem_wmask`, `dmem_addr`, `dmem_wdata` = 0;
  - `mem_stall=0`; FSM in `IDLE`.
- **Latency:**
  - pass-through: 1 cycle;
  - memory op: `1+k` cycles, where `k≥1` is the memory latency.
- **Request ordering:**
  - at most one outstanding request;
  - a request is never reissued while in `WAIT`.
- **`dmem_resp` handling:**
  - sampled only in `WAIT`;
  - a resp seen in `IDLE` is ignored;
  - a resp in the same cycle as issue is illegal (memory latency ≥1).
- **Upstream contract:** `ex_mem_reg` is held stable whenever `mem_stall=1`. The stage does not re-latch the request.
- **Back-to-back memory ops:**
  - cycle of resp: op A commits, FSM returns to `IDLE`;
  - next cycle: op B issues.
  - There is no zero-gap issue on the resp cycle.
- **Reset during `WAIT`:**
  - FSM goes to `IDLE`;
  - a pending response arriving afterwards is ignored;
  - no `mem_wb_reg` write occurs for the aborted op.
- **Masks:** all outputs except `mem_wb_reg` are combinational from state and `ex_mem_reg`. Masks are registered nowhere.

## Structure
- **Package additions** in `rv32i_types`:
  - `mem_state_t` (`IDLE`, `WAIT`);
  - `mem_f3_t` enum (lb, lh, lw, lbu, lhu / sb, sh, sw);
  - the `misalign_s` and `dmem_rdata_s` fields in `mem_wb_stage_reg_t`.
- **Sub-module:** `mem_mask_gen`, purely combinational. It takes `funct3`, `off`, `mem_read`, `mem_write`, `rs2_v` and produces `rmask`, `wmask`, `wdata`, `misalign`.
- **Top level:** FSM, stall logic, `mem_wb_reg` flops.

## Test plan
- **Pass-through ALU op:** `valid`, `alu_out=0x1234` → next cycle `mem_wb_reg.alu_out_s=0x1234`, `valid=1`, `mem_stall` never high.
- **lb, `alu_out=0x1003`, resp after 3 cycles with rdata=0xAB000000:**
  - `dmem_addr=0x1000`, `rmask=4'b1000` for one cycle;
  - `mem_stall` high for 3 cycles, with `valid=0` bubbles;
  - then `dmem_rdata_s=0xAB000000`, `dmem_addr_s=0x1003`.
- **sh, `alu_out=0x2002`, `rs2_v=0x0000BEEF`:** `wmask=4'b1100`, `wdata=0xBEEF0000`, `addr=0x2000`; commit on resp.
- **lw, `alu_out=0x3001`:** no mask ever asserted, `mem_stall=0`, next cycle `misalign_s=1` and `regf_we=0`.
- **Load then store back-to-back, resp latency 1:**
  - exactly one request outstanding at a time;
  - store issues the cycle after the load's resp;
  - two valid `mem_wb_reg` commits.
- **`rst` pulsed while in `WAIT`, then stray `dmem_resp`:** FSM `IDLE`, `mem_wb_reg.valid=0`, resp ignored, `mem_stall=0`.
